arith_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle arithmetic unit in the out-of-order core's execute stage. It accepts one issued integer op per cycle from the reservation station with a valid/ready handshake and carries a ROB tag. Results are produced after a fixed LATENCY, with writeback backpressure and a pipeline flush. RV32I/RV64I ALU ops are supported, plus optional M-extension multiplies. Unsupported encodings are reported as illegal instead of producing undefined results.

---
 rtl/arith_pkg.sv | 53 +++++
 rtl/arith_pipe_if.sv | 36 +++
 rtl/alu_core.sv | 40 ++++
 rtl/arith_pipe.sv | 195 +++++++++++++++++++
 tb/tb_arith_pipe.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared decode constants, ALU function encoding and immediate helpers for the
// integer execute units.
package arith_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU
    } alu_op_e;

    // I-type immediate: inst[31:20], sign-extended to 32 bits.
    function automatic logic [31:0] imm_i(input logic [11:0] imm12);
        return {{20{imm12[11]}}, imm12};
    endfunction

    // U-type immediate: inst[31:12] placed in the upper 20 bits.
    function automatic logic [31:0] imm_u(input logic [19:0] imm20);
        return {imm20, 12'b0};
    endfunction

endpackage

// File: rtl/arith_pipe_if.sv
// Issue and writeback channels between the reservation station / CDB and the
// pipelined arithmetic unit.
interface arith_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    // Both channels use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both 1; a raised valid holds its payload until then.
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [TAG_W-1:0]  issue_tag_i;
    logic [XLEN-1:0]   pc_i;
    logic [31:0]       inst_i;
    logic [XLEN-1:0]   rs1_value_i;
    logic [XLEN-1:0]   rs2_value_i;

    logic              writeback_valid_o;
    logic              writeback_ready_i;
    logic [TAG_W-1:0]  writeback_tag_o;
    logic [XLEN-1:0]   writeback_value_o;
    logic              writeback_illegal_o;

    modport master (
        output issue_valid_i, issue_tag_i, pc_i, inst_i, rs1_value_i, rs2_value_i,
        output writeback_ready_i,
        input  issue_ready_o,
        input  writeback_valid_o, writeback_tag_o, writeback_value_o, writeback_illegal_o
    );

    modport slave (
        input  issue_valid_i, issue_tag_i, pc_i, inst_i, rs1_value_i, rs2_value_i,
        input  writeback_ready_i,
        output issue_ready_o,
        output writeback_valid_o, writeback_tag_o, writeback_value_o, writeback_illegal_o
    );
endinterface

// File: rtl/alu_core.sv
// Combinational integer ALU shared by the arithmetic pipe and the branch unit.
// Multiply functions are evaluated by the caller and yield 0 here.
module alu_core
    import arith_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  alu_op_e         func,
    output logic [XLEN-1:0] result
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           lt_signed;
    logic           lt_unsigned;

    assign shamt       = op2[SHW-1:0];
    assign lt_signed   = $signed(op1) < $signed(op2);
    assign lt_unsigned = op1 < op2;

    always_comb begin
        result = '0;
        case (func)
            ALU_ADD:  result = op1 + op2;
            ALU_SUB:  result = op1 - op2;
            ALU_SLL:  result = op1 << shamt;
            ALU_SLT:  result = XLEN'(lt_signed);
            ALU_SLTU: result = XLEN'(lt_unsigned);
            ALU_XOR:  result = op1 ^ op2;
            ALU_SRL:  result = op1 >> shamt;
            ALU_SRA:  result = $unsigned($signed(op1) >>> shamt);
            ALU_OR:   result = op1 | op2;
            ALU_AND:  result = op1 & op2;
            ALU_PASS: result = op2;
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/arith_pipe.sv
// Pipelined integer execute unit: decode + ALU/multiply ahead of S1, then
// LATENCY stall-able register stages with flush; results leave from the last stage.
module arith_pipe
    import arith_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 6,
    parameter int LATENCY    = 2,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         flush_i,
    output logic         busy_o,
    arith_pipe_if.slave  bus
);
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        logic             illegal;
    } stage_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i_x;
    logic [XLEN-1:0] imm_u_x;
    logic            shift_ok;
    logic            unused_rd;

    alu_op_e         alu_func;
    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic [XLEN-1:0] alu_result;
    logic            illegal;
    logic            is_mul;

    logic signed [XLEN:0]     mul_a;
    logic signed [XLEN:0]     mul_b;
    logic signed [2*XLEN+1:0] mul_p;
    logic [XLEN-1:0]          mul_result;
    logic                     unused_mul;

    stage_t          stage_q [LATENCY];
    stage_t          entry;
    logic            stall;
    logic            issue_fire;

    assign opcode    = bus.inst_i[6:0];
    assign funct3    = bus.inst_i[14:12];
    assign funct7    = bus.inst_i[31:25];
    assign imm_i_x   = XLEN'($signed(imm_i(bus.inst_i[31:20])));
    assign imm_u_x   = XLEN'($signed(imm_u(bus.inst_i[31:12])));
    assign unused_rd = ^bus.inst_i[11:7];

    // Immediate shifts: bit 30 selects arithmetic; bit 25 is shamt[5] on RV64 only.
    assign shift_ok = ({bus.inst_i[31], bus.inst_i[29:26]} == 5'd0) &&
                      ((XLEN == 64) || !bus.inst_i[25]);

    always_comb begin
        alu_func = ALU_PASS;
        alu_op1  = bus.rs1_value_i;
        alu_op2  = '0;
        illegal  = 1'b1;
        case (opcode)
            OPC_OP_IMM: begin
                alu_op2 = imm_i_x;
                illegal = 1'b0;
                case (funct3)
                    F3_ADD:  alu_func = ALU_ADD;
                    F3_SLT:  alu_func = ALU_SLT;
                    F3_SLTU: alu_func = ALU_SLTU;
                    F3_XOR:  alu_func = ALU_XOR;
                    F3_OR:   alu_func = ALU_OR;
                    F3_AND:  alu_func = ALU_AND;
                    F3_SLL: begin
                        if (shift_ok && !bus.inst_i[30]) alu_func = ALU_SLL;
                        else                             illegal  = 1'b1;
                    end
                    default: begin
                        if (shift_ok) alu_func = bus.inst_i[30] ? ALU_SRA : ALU_SRL;
                        else          illegal  = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                alu_op2 = bus.rs2_value_i;
                case (funct7)
                    F7_BASE: begin
                        illegal = 1'b0;
                        case (funct3)
                            F3_ADD:  alu_func = ALU_ADD;
                            F3_SLL:  alu_func = ALU_SLL;
                            F3_SLT:  alu_func = ALU_SLT;
                            F3_SLTU: alu_func = ALU_SLTU;
                            F3_XOR:  alu_func = ALU_XOR;
                            F3_SR:   alu_func = ALU_SRL;
                            F3_OR:   alu_func = ALU_OR;
                            default: alu_func = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == F3_ADD) begin
                            alu_func = ALU_SUB;
                            illegal  = 1'b0;
                        end else if (funct3 == F3_SR) begin
                            alu_func = ALU_SRA;
                            illegal  = 1'b0;
                        end
                    end
                    F7_MULDIV: begin
                        // DIV/REM (funct3[2] = 1) stay illegal.
                        if (ENABLE_MUL && !funct3[2]) begin
                            illegal = 1'b0;
                            case (funct3[1:0])
                                2'b00:   alu_func = ALU_MUL;
                                2'b01:   alu_func = ALU_MULH;
                                2'b10:   alu_func = ALU_MULHSU;
                                default: alu_func = ALU_MULHU;
                            endcase
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                alu_op2 = imm_u_x;
                illegal = 1'b0;
            end
            OPC_AUIPC: begin
                alu_func = ALU_ADD;
                alu_op1  = bus.pc_i;
                alu_op2  = imm_u_x;
                illegal  = 1'b0;
            end
            OPC_JAL, OPC_JALR: begin
                alu_func = ALU_ADD;
                alu_op1  = bus.pc_i;
                alu_op2  = XLEN'(4);
                illegal  = 1'b0;
            end
            default: illegal = 1'b1;
        endcase
    end

    alu_core #(.XLEN(XLEN)) u_alu (
        .op1    (alu_op1),
        .op2    (alu_op2),
        .func   (alu_func),
        .result (alu_result)
    );

    // One extra operand bit turns all three signedness mixes into one signed multiply.
    assign is_mul = (alu_func == ALU_MUL) || (alu_func == ALU_MULH) ||
                    (alu_func == ALU_MULHSU) || (alu_func == ALU_MULHU);
    assign mul_a  = {((alu_func == ALU_MULH) || (alu_func == ALU_MULHSU)) &
                     bus.rs1_value_i[XLEN-1], bus.rs1_value_i};
    assign mul_b  = {(alu_func == ALU_MULH) & bus.rs2_value_i[XLEN-1], bus.rs2_value_i};
    assign mul_p  = mul_a * mul_b;
    assign mul_result = (alu_func == ALU_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
    assign unused_mul = ^mul_p[2*XLEN+1:2*XLEN];

    assign stall             = stage_q[LATENCY-1].valid & ~bus.writeback_ready_i;
    assign bus.issue_ready_o = ~stall;
    assign issue_fire        = bus.issue_valid_i & ~stall & ~flush_i;

    always_comb begin
        entry.valid   = issue_fire;
        entry.tag     = bus.issue_tag_i;
        entry.illegal = illegal;
        entry.value   = illegal ? '0 : (is_mul ? mul_result : alu_result);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i].valid <= 1'b0;
        end else if (!stall) begin
            stage_q[0] <= entry;
            for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < LATENCY; i++) busy_o = busy_o | stage_q[i].valid;
    end

    assign bus.writeback_valid_o   = stage_q[LATENCY-1].valid;
    assign bus.writeback_tag_o     = stage_q[LATENCY-1].tag;
    assign bus.writeback_value_o   = stage_q[LATENCY-1].value;
    assign bus.writeback_illegal_o = stage_q[LATENCY-1].illegal;
endmodule

// File: tb/tb_arith_pipe.sv
// Directed bench for arith_pipe (XLEN=32, LATENCY=2): vector table plus
// stall, flush and reset sequences; a second instance has multiplies disabled.
module tb_arith_pipe;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    logic clk = 1'b0;
    logic reset_ni;
    logic flush;
    logic busy;
    logic busy2;
    int   assert_cnt = 0;
    int   fail_cnt   = 0;

    logic             collect = 1'b0;
    logic [TAG_W-1:0] exp_q[$];
    logic [TAG_W-1:0] got_q[$];

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] exp_val;
        logic        exp_ill;
        logic        is_mul;
    } vec_t;
    vec_t vecs[$];

    arith_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();
    arith_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus2();

    arith_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .LATENCY(2), .ENABLE_MUL(1'b1)) u_dut (
        .clk_i(clk), .reset_ni(reset_ni), .flush_i(flush), .busy_o(busy), .bus(bus)
    );
    arith_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .LATENCY(2), .ENABLE_MUL(1'b0)) u_dut_nomul (
        .clk_i(clk), .reset_ni(reset_ni), .flush_i(flush), .busy_o(busy2), .bus(bus2)
    );

    assign bus2.issue_valid_i     = bus.issue_valid_i;
    assign bus2.issue_tag_i       = bus.issue_tag_i;
    assign bus2.pc_i              = bus.pc_i;
    assign bus2.inst_i            = bus.inst_i;
    assign bus2.rs1_value_i       = bus.rs1_value_i;
    assign bus2.rs2_value_i       = bus.rs2_value_i;
    assign bus2.writeback_ready_i = bus.writeback_ready_i;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (collect && bus.writeback_valid_o && bus.writeback_ready_i)
            got_q.push_back(bus.writeback_tag_o);
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm, 5'd2, f3, 5'd1, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd3, 5'd2, f3, 5'd1, 7'h33};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [6:0] op);
        return {imm, 5'd1, op};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a later rising edge.
    task automatic run_op(input string name, input logic [31:0] inst, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] pc,
                          input logic [TAG_W-1:0] tag, input logic [31:0] exp_val,
                          input logic exp_ill, input logic is_mul);
        bus.issue_valid_i = 1'b1;
        bus.issue_tag_i   = tag;
        bus.inst_i        = inst;
        bus.rs1_value_i   = rs1;
        bus.rs2_value_i   = rs2;
        bus.pc_i          = pc;
        @(posedge clk);
        #1 bus.issue_valid_i = 1'b0;
        @(negedge clk);
        check({name, "_early_valid"}, 64'(bus.writeback_valid_o), 64'(0));
        @(negedge clk);
        check({name, "_valid"},   64'(bus.writeback_valid_o),   64'(1));
        check({name, "_tag"},     64'(bus.writeback_tag_o),     64'(tag));
        check({name, "_value"},   64'(bus.writeback_value_o),   64'(exp_val));
        check({name, "_illegal"}, 64'(bus.writeback_illegal_o), 64'(exp_ill));
        check({name, "_nomul_valid"},   64'(bus2.writeback_valid_o), 64'(1));
        check({name, "_nomul_value"},   64'(bus2.writeback_value_o),
              64'(is_mul ? 32'd0 : exp_val));
        check({name, "_nomul_illegal"}, 64'(bus2.writeback_illegal_o),
              64'(is_mul ? 1'b1 : exp_ill));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;

        vecs.push_back('{enc_r(7'h20, 3'b000), 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{enc_i(12'h404, 3'b101, 7'h13), 32'h80000000, 32'h0, 32'h0, 32'hF8000000, 1'b0, 1'b0});
        vecs.push_back('{enc_r(7'h00, 3'b011), 32'h1, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 1'b0});
        vecs.push_back('{enc_r(7'h00, 3'b010), 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{enc_r(7'h01, 3'b001), 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'h01, 3'b011), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'h01, 3'b000), 32'hFFFFFFFF, 32'h2, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'h01, 3'b010), 32'hFFFFFFFF, 32'h2, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1});
        vecs.push_back('{enc_r(7'h01, 3'b010), 32'h2, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 1'b1});
        vecs.push_back('{enc_i(12'h004, 3'b101, 7'h13), 32'h80000000, 32'h0, 32'h0, 32'h08000000, 1'b0, 1'b0});
        vecs.push_back('{enc_r(7'h00, 3'b001), 32'h1, 32'd31, 32'h0, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{enc_r(7'h00, 3'b101), 32'h80000000, 32'h24, 32'h0, 32'h08000000, 1'b0, 1'b0});
        vecs.push_back('{enc_r(7'h20, 3'b101), 32'h80000000, 32'h1, 32'h0, 32'hC0000000, 1'b0, 1'b0});
        vecs.push_back('{enc_r(7'h00, 3'b000), 32'hFFFFFFFF, 32'h2, 32'h0, 32'h1, 1'b0, 1'b0});
        vecs.push_back('{enc_i(12'h0FF, 3'b100, 7'h13), 32'h0000F0F0, 32'h0, 32'h0, 32'h0000F00F, 1'b0, 1'b0});
        vecs.push_back('{enc_i(12'h800, 3'b110, 7'h13), 32'h1, 32'h0, 32'h0, 32'hFFFFF801, 1'b0, 1'b0});
        vecs.push_back('{enc_i(12'hFFF, 3'b111, 7'h13), 32'h12345678, 32'h0, 32'h0, 32'h12345678, 1'b0, 1'b0});
        vecs.push_back('{enc_i(12'hFFF, 3'b011, 7'h13), 32'h5, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0});
        vecs.push_back('{enc_i(12'hFFF, 3'b010, 7'h13), 32'h5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{enc_r(7'h00, 3'b110), 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hFFF0FFF0, 1'b0, 1'b0});
        vecs.push_back('{enc_r(7'h00, 3'b100), 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0FF00FF0, 1'b0, 1'b0});
        vecs.push_back('{enc_u(20'h12345, 7'h37), 32'h5, 32'h6, 32'h0, 32'h12345000, 1'b0, 1'b0});
        vecs.push_back('{enc_i(12'h000, 3'b000, 7'h67), 32'h5, 32'h0, 32'h2000, 32'h2004, 1'b0, 1'b0});
        vecs.push_back('{enc_i(12'h401, 3'b001, 7'h13), 32'h5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{enc_i(12'h021, 3'b001, 7'h13), 32'h5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{enc_i(12'h801, 3'b101, 7'h13), 32'h5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{enc_r(7'h01, 3'b100), 32'h7, 32'h2, 32'h0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{enc_r(7'h20, 3'b001), 32'h7, 32'h2, 32'h0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{enc_r(7'h02, 3'b000), 32'h7, 32'h2, 32'h0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{enc_i(12'h000, 3'b000, 7'h03), 32'h7, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0});

        reset_ni              = 1'b0;
        flush                 = 1'b0;
        bus.issue_valid_i     = 1'b0;
        bus.issue_tag_i       = '0;
        bus.inst_i            = '0;
        bus.rs1_value_i       = '0;
        bus.rs2_value_i       = '0;
        bus.pc_i              = '0;
        bus.writeback_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid",   64'(bus.writeback_valid_o),   64'(0));
        check("reset_tag",     64'(bus.writeback_tag_o),     64'(0));
        check("reset_value",   64'(bus.writeback_value_o),   64'(0));
        check("reset_illegal", 64'(bus.writeback_illegal_o), 64'(0));
        check("reset_busy",    64'(busy),                    64'(0));
        check("reset_ready",   64'(bus.issue_ready_o),       64'(1));
        @(posedge clk);
        #1 reset_ni = 1'b1;
        @(posedge clk);
        #1;

        run_op("addi", enc_i(12'hFFD, 3'b000, 7'h13), 32'd5, 32'd0, 32'd0, 6'd7, 32'd2, 1'b0, 1'b0);
        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i].inst, vecs[i].rs1, vecs[i].rs2, vecs[i].pc,
                   TAG_W'(i + 8), vecs[i].exp_val, vecs[i].exp_ill, vecs[i].is_mul);

        // Back-to-back issue with a three-cycle writeback stall.
        collect = 1'b1;
        exp_q.push_back(6'd1);
        exp_q.push_back(6'd2);
        exp_q.push_back(6'd3);
        bus.inst_i        = enc_r(7'h00, 3'b000);
        bus.issue_valid_i = 1'b1;
        bus.issue_tag_i   = 6'd1;
        @(posedge clk);
        #1 bus.issue_tag_i = 6'd2;
        @(posedge clk);
        #1 bus.issue_tag_i = 6'd3;
        bus.writeback_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_issue_ready", c), 64'(bus.issue_ready_o),     64'(0));
            check($sformatf("stall%0d_wb_valid", c),    64'(bus.writeback_valid_o), 64'(1));
            check($sformatf("stall%0d_wb_tag", c),      64'(bus.writeback_tag_o),   64'(1));
            @(posedge clk);
        end
        #1 bus.writeback_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.issue_valid_i = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (bus.writeback_valid_o && bus.writeback_tag_o == 6'd3) found = 1'b1;
        end
        check("stall_tag3_seen", 64'(found), 64'(1));
        check("stall_busy_at_tag3", 64'(busy), 64'(1));
        @(negedge clk);
        check("stall_busy_after_tag3", 64'(busy), 64'(0));
        collect = 1'b0;
        check("stall_retired_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("stall_order%0d", k),
                  64'((k < got_q.size()) ? got_q[k] : 6'h3F), 64'(exp_q[k]));
        @(posedge clk);
        #1;

        // Flush while stalled with a full pipe and a pending issue.
        bus.writeback_ready_i = 1'b0;
        bus.issue_valid_i     = 1'b1;
        bus.issue_tag_i       = 6'd4;
        @(posedge clk);
        #1 bus.issue_tag_i = 6'd5;
        @(posedge clk);
        #1 bus.issue_tag_i = 6'd6;
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy_before", 64'(busy), 64'(1));
        @(posedge clk);
        #1 flush = 1'b0;
        bus.issue_valid_i     = 1'b0;
        bus.writeback_ready_i = 1'b1;
        @(negedge clk);
        check("flush_busy_after", 64'(busy), 64'(0));
        check("flush_nomul_busy", 64'(busy2), 64'(0));
        for (int c = 0; c < 3; c++) begin
            check($sformatf("flush_quiet%0d", c), 64'(bus.writeback_valid_o), 64'(0));
            @(negedge clk);
        end

        // Issue in the same cycle as flush on an empty pipe is dropped.
        @(posedge clk);
        #1 bus.issue_valid_i = 1'b1;
        bus.issue_tag_i = 6'd9;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        bus.issue_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("flush_drop_valid%0d", c), 64'(bus.writeback_valid_o), 64'(0));
            check($sformatf("flush_drop_busy%0d", c),  64'(busy), 64'(0));
        end

        // Asynchronous reset while stalled with a valid last stage.
        @(posedge clk);
        #1 bus.writeback_ready_i = 1'b0;
        bus.issue_valid_i = 1'b1;
        bus.issue_tag_i   = 6'd20;
        bus.inst_i        = enc_i(12'h001, 3'b000, 7'h13);
        bus.rs1_value_i   = 32'h10;
        @(posedge clk);
        #1 bus.issue_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("areset_pre_valid", 64'(bus.writeback_valid_o), 64'(1));
        check("areset_pre_value", 64'(bus.writeback_value_o), 64'(32'h11));
        #2 reset_ni = 1'b0;
        #1;
        check("areset_valid", 64'(bus.writeback_valid_o), 64'(0));
        check("areset_value", 64'(bus.writeback_value_o), 64'(0));
        check("areset_tag",   64'(bus.writeback_tag_o),   64'(0));
        check("areset_busy",  64'(busy),                  64'(0));
        check("areset_nomul_valid", 64'(bus2.writeback_valid_o), 64'(0));
        @(posedge clk);
        #1 reset_ni = 1'b1;
        bus.writeback_ready_i = 1'b1;
        @(posedge clk);
        #1;
        run_op("auipc", enc_u(20'h00002, 7'h17), 32'h0, 32'h0, 32'h1000, 6'd21, 32'h3000, 1'b0, 1'b0);
        run_op("jal", enc_u(20'h12345, 7'h6F), 32'h0, 32'h0, 32'h1000, 6'd22, 32'h1004, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
